// File: rtl/pe0_pkg.sv
// Shared types for the pe0 butterfly datapath.
//   coeff_t   : one coefficient, range 0..3328 (fits in 12 bits)
//   pe_mode_e : operation selected on pe0's ctrl_i
`timescale 1ns/1ps
package pe0_pkg;

  typedef logic [11:0] coeff_t;

  typedef enum logic [1:0] {
    PE_MODE_NTT    = 2'd0,
    PE_MODE_INTT   = 2'd1,
    PE_MODE_ADDSUB = 2'd2,
    PE_MODE_MUL    = 2'd3
  } pe_mode_e;

endpackage

// File: rtl/pe0_issue_ctrl.sv
// pe0_issue_ctrl
//   Issue stage in front of pe0 (butterfly unit). Takes operand triples plus a
//   mode over valid/ready and registers them onto pe0's inputs. pe0 uses ctrl_i
//   combinationally along its whole pipeline, so ctrl_o only changes on an
//   accept made while nothing is in flight. A request for a different mode
//   while items are in flight parks the controller in DRAIN until pe0 is empty.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | normal issue; same-mode operands stream at one per cycle
//   DRAIN | pending operand has a new mode; wait for all credits to return
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low (shared with pe0)
//   in_valid_i    operand valid from upstream
//   in_ready_o    operand accepted when in_valid_i & in_ready_o
//   in_a_i/in_b_i/in_w_i  operands a, b and twiddle w
//   in_mode_i     operation mode for this operand
//   a0_o/b0_o/w0_o  registered operands to pe0 (zero when not valid)
//   ctrl_o        registered mode to pe0 ctrl_i (held between accepts)
//   valid_o       to pe0 valid_i
//   pe_valid_i    pe0 result valid, returns one credit
//   draining_o    high while in DRAIN
//   busy_o        at least one item in flight
//   underflow_o   sticky: a return arrived with nothing in flight
`timescale 1ns/1ps
module pe0_issue_ctrl
  import pe0_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  coeff_t   in_a_i,
  input  coeff_t   in_b_i,
  input  coeff_t   in_w_i,
  input  pe_mode_e in_mode_i,
  output coeff_t   a0_o,
  output coeff_t   b0_o,
  output coeff_t   w0_o,
  output pe_mode_e ctrl_o,
  output logic     valid_o,
  input  logic     pe_valid_i,
  output logic     draining_o,
  output logic     busy_o,
  output logic     underflow_o
);

  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic cnt_zero;
  logic mode_match;
  logic mode_ok;
  logic credit;
  logic accept;
  logic retire;

  assign cnt_zero   = (cnt_q == '0);
  assign mode_match = (in_mode_i == ctrl_o);

  // A new mode may only enter an empty pipeline; a return in the same cycle
  // frees a slot, so a full counter does not stall when pe_valid_i is high.
  assign mode_ok    = mode_match | cnt_zero;
  assign credit     = (cnt_q < CNT_MAX) | pe_valid_i;
  assign in_ready_o = mode_ok & credit;
  assign accept     = in_valid_i & in_ready_o;

  // Returns with nothing outstanding are flagged, never counted.
  assign retire     = pe_valid_i & ~cnt_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (in_valid_i && !mode_match && !cnt_zero) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave when the pending operand finally goes in, or when upstream
        // withdraws it.
        if (!in_valid_i || accept) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, retire})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      underflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pe_valid_i && cnt_zero) begin
        underflow_o <= 1'b1;
      end
    end
  end

  // Operands are zeroed on idle cycles; ctrl_o is held because pe0 still
  // decodes it for items already travelling down its pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_o    <= '0;
      b0_o    <= '0;
      w0_o    <= '0;
      ctrl_o  <= PE_MODE_NTT;
      valid_o <= 1'b0;
    end else if (accept) begin
      a0_o    <= in_a_i;
      b0_o    <= in_b_i;
      w0_o    <= in_w_i;
      ctrl_o  <= in_mode_i;
      valid_o <= 1'b1;
    end else begin
      a0_o    <= '0;
      b0_o    <= '0;
      w0_o    <= '0;
      valid_o <= 1'b0;
    end
  end

  assign draining_o = (state_q == ST_DRAIN);
  assign busy_o     = ~cnt_zero;

endmodule

// File: tb/tb_pe0_issue_ctrl.sv
`timescale 1ns/1ps
module tb_pe0_issue_ctrl;
  import pe0_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // index 0: MAX_INFLIGHT=8 with pe0 stub latency 3
  // index 1: MAX_INFLIGHT=2 with pe0 stub latency 5
  logic     in_valid [2];
  coeff_t   in_a     [2];
  coeff_t   in_b     [2];
  coeff_t   in_w     [2];
  pe_mode_e in_mode  [2];

  logic     in_ready_0, valid_0, draining_0, busy_0, underflow_0, pe_valid_0;
  coeff_t   a0_0, b0_0, w0_0;
  pe_mode_e ctrl_0;
  logic     in_ready_1, valid_1, draining_1, busy_1, underflow_1, pe_valid_1;
  coeff_t   a0_1, b0_1, w0_1;
  pe_mode_e ctrl_1;

  logic       force_ret;
  logic [1:0] sr0;
  logic [3:0] sr1;

  pe0_issue_ctrl #(.MAX_INFLIGHT(8)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready_0),
    .in_a_i(in_a[0]), .in_b_i(in_b[0]), .in_w_i(in_w[0]), .in_mode_i(in_mode[0]),
    .a0_o(a0_0), .b0_o(b0_0), .w0_o(w0_0), .ctrl_o(ctrl_0), .valid_o(valid_0),
    .pe_valid_i(pe_valid_0), .draining_o(draining_0), .busy_o(busy_0),
    .underflow_o(underflow_0)
  );

  pe0_issue_ctrl #(.MAX_INFLIGHT(2)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready_1),
    .in_a_i(in_a[1]), .in_b_i(in_b[1]), .in_w_i(in_w[1]), .in_mode_i(in_mode[1]),
    .a0_o(a0_1), .b0_o(b0_1), .w0_o(w0_1), .ctrl_o(ctrl_1), .valid_o(valid_1),
    .pe_valid_i(pe_valid_1), .draining_o(draining_1), .busy_o(busy_1),
    .underflow_o(underflow_1)
  );

  // pe0 stubs: pure delay lines on valid, reset together with the DUTs
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr0 <= '0;
      sr1 <= '0;
    end else begin
      sr0 <= {sr0[0], valid_0};
      sr1 <= {sr1[2:0], valid_1};
    end
  end
  assign pe_valid_0 = sr0[1] | force_ret;
  assign pe_valid_1 = sr1[3];

  // ---------------- scoreboard / reference model for dut0 ----------------
  typedef struct packed {
    coeff_t   a;
    coeff_t   b;
    coeff_t   w;
    pe_mode_e m;
  } item_t;

  item_t    sb[$];
  pe_mode_e flight[$];
  int       m_cnt;
  pe_mode_e m_ctrl;
  bit       m_valid, m_drain, m_uf;
  int       m_returns = 0;
  bit       exp_ready, acc, ret, drain_n;
  item_t    it;

  always @(negedge clk) begin
    if (!rst) begin
      m_cnt   = 0;
      m_ctrl  = PE_MODE_NTT;
      m_valid = 0;
      m_drain = 0;
      m_uf    = 0;
      sb.delete();
      flight.delete();
    end else begin
      exp_ready = ((in_mode[0] == m_ctrl) || (m_cnt == 0)) && ((m_cnt < 8) || pe_valid_0);
      n_checks++;
      if (in_ready_0 !== exp_ready || busy_0 !== (m_cnt != 0) || draining_0 !== m_drain ||
          ctrl_0 !== m_ctrl || valid_0 !== m_valid || underflow_0 !== m_uf) begin
        n_fail++;
        $display("FAIL mon_ctrl t=%0t ready=%b exp %b busy=%b exp %b draining=%b exp %b ctrl=%0d exp %0d valid=%b exp %b underflow=%b exp %b",
                 $time, in_ready_0, exp_ready, busy_0, (m_cnt != 0), draining_0, m_drain,
                 ctrl_0, m_ctrl, valid_0, m_valid, underflow_0, m_uf);
      end
      if (valid_0 === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_data t=%0t unexpected issue a=%0d b=%0d w=%0d mode=%0d, expected none",
                   $time, a0_0, b0_0, w0_0, ctrl_0);
        end else begin
          it = sb.pop_front();
          if ({a0_0, b0_0, w0_0, ctrl_0} !== it) begin
            n_fail++;
            $display("FAIL mon_data t=%0t got a=%0d b=%0d w=%0d mode=%0d, expected a=%0d b=%0d w=%0d mode=%0d",
                     $time, a0_0, b0_0, w0_0, ctrl_0, it.a, it.b, it.w, it.m);
          end
        end
        n_checks++;
        if (flight.size() != 0 && flight[0] !== ctrl_0) begin
          n_fail++;
          $display("FAIL mixed_mode t=%0t issued mode=%0d while mode=%0d in flight",
                   $time, ctrl_0, flight[0]);
        end
        flight.push_back(ctrl_0);
      end else begin
        n_checks++;
        if (a0_0 !== '0 || b0_0 !== '0 || w0_0 !== '0) begin
          n_fail++;
          $display("FAIL idle_data t=%0t a=%0d b=%0d w=%0d, expected 0 0 0", $time, a0_0, b0_0, w0_0);
        end
      end
      if (pe_valid_0 && flight.size() != 0) begin
        void'(flight.pop_front());
        m_returns++;
      end

      acc = in_valid[0] && exp_ready;
      ret = pe_valid_0;
      if (!m_drain) drain_n = in_valid[0] && (in_mode[0] != m_ctrl) && (m_cnt != 0);
      else          drain_n = in_valid[0] && !acc;
      if (acc) begin
        sb.push_back(item_t'({in_a[0], in_b[0], in_w[0], in_mode[0]}));
        m_ctrl = in_mode[0];
      end
      m_valid = acc;
      if (ret && m_cnt == 0) m_uf = 1;
      m_cnt   = m_cnt + (acc ? 1 : 0) - ((ret && m_cnt != 0) ? 1 : 0);
      m_drain = drain_n;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input int idx, input coeff_t a, input coeff_t b, input coeff_t w,
                      input pe_mode_e m, input int budget, output bit got, output int stalls);
    in_valid[idx] = 1'b1;
    in_a[idx]     = a;
    in_b[idx]     = b;
    in_w[idx]     = w;
    in_mode[idx]  = m;
    got    = 1'b0;
    stalls = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((idx == 0) ? in_ready_0 : in_ready_1) === 1'b1) begin
        got = 1'b1;
        break;
      end
      stalls++;
    end
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_0 && !busy_1 && !valid_0 && !valid_1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle busy0=%b busy1=%b, expected both 0 within 100 cycles", name, busy_0, busy_1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit got;
    int st;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_0 !== 1'b0 || ctrl_0 !== PE_MODE_NTT || busy_0 !== 1'b0 || underflow_0 !== 1'b0 ||
        a0_0 !== '0 || in_ready_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init valid=%b ctrl=%0d busy=%b uf=%b a0=%0d ready=%b, expected 0 0 0 0 0 1",
               valid_0, ctrl_0, busy_0, underflow_0, a0_0, in_ready_0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, coeff_t'(100 + i), coeff_t'(200 + i), coeff_t'(300 + i), PE_MODE_INTT, 4, got, st);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL reset_fill op %0d not accepted, expected accept", i);
      end
    end
    n_checks++;
    if (ctrl_0 !== PE_MODE_INTT || busy_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill ctrl=%0d busy=%b, expected ctrl=1 busy=1", ctrl_0, busy_0);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (valid_0 !== 1'b0 || ctrl_0 !== PE_MODE_NTT || busy_0 !== 1'b0 || a0_0 !== '0) begin
      n_fail++;
      $display("FAIL reset_async valid=%b ctrl=%0d busy=%b a0=%0d, expected 0 0 0 0",
               valid_0, ctrl_0, busy_0, a0_0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready_0 !== 1'b1 || busy_0 !== 1'b0 || valid_0 !== 1'b0 || pe_valid_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release ready=%b busy=%b valid=%b pe_valid=%b, expected 1 0 0 0",
               in_ready_0, busy_0, valid_0, pe_valid_0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit [19:0] v, pv, bs;
    int        ctrl_bad = 0, stalls = 0, occ = 0, occ_max = 0, nacc = 0, nv = 0, first = -1, last_pv = -1;
    fork
      begin
        bit got;
        int st;
        for (int i = 0; i < 7; i++) begin
          send(0, coeff_t'(10 + i), 12'd2, 12'd5, PE_MODE_NTT, 4, got, st);
          if (got) nacc++;
          stalls += st;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          v[i]  = valid_0;
          pv[i] = pe_valid_0;
          bs[i] = busy_0;
          if (ctrl_0 !== PE_MODE_NTT) ctrl_bad++;
          if (occ > occ_max) occ_max = occ;
          occ = occ + ((in_valid[0] && in_ready_0) ? 1 : 0) - (pe_valid_0 ? 1 : 0);
        end
      end
    join
    for (int i = 0; i < 20; i++) begin
      if (v[i]) begin
        nv++;
        if (first < 0) first = i;
      end
      if (pv[i]) last_pv = i;
    end
    n_checks++;
    if (nacc != 7 || stalls != 0) begin
      n_fail++;
      $display("FAIL stream_b2b accepted=%0d stalls=%0d, expected 7 0", nacc, stalls);
    end
    n_checks++;
    if (nv != 7 || first != 1 || v[7:1] !== 7'h7f) begin
      n_fail++;
      $display("FAIL stream_valid pulses=%0d first=%0d pattern=%b, expected 7 1 contiguous", nv, first, v);
    end
    n_checks++;
    if (ctrl_bad != 0) begin
      n_fail++;
      $display("FAIL stream_ctrl non-NTT cycles=%0d, expected 0", ctrl_bad);
    end
    n_checks++;
    if (occ_max != 3) begin
      n_fail++;
      $display("FAIL stream_maxcnt got %0d, expected 3", occ_max);
    end
    n_checks++;
    if (last_pv != 9 || bs[9] !== 1'b1 || bs[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_busy last_pe_valid=%0d busy@last=%b busy@next=%b, expected 9 1 0",
               last_pv, bs[9], bs[10]);
    end
    wait_idle("stream");
  endtask

  task automatic test_mode_drain();
    bit [11:0] rdy, drn, v;
    int        st_intt = -1, ctrl_ntt = 0;
    pe_mode_e  ctrl_after = PE_MODE_MUL;
    bit        all_got = 1'b1;
    fork
      begin
        bit got;
        int st;
        for (int i = 0; i < 3; i++) begin
          send(0, coeff_t'(50 + i), coeff_t'(60 + i), coeff_t'(70 + i), PE_MODE_NTT, 4, got, st);
          if (!got) all_got = 1'b0;
        end
        send(0, 12'd3000, 12'd3328, 12'd17, PE_MODE_INTT, 10, got, st);
        if (!got) all_got = 1'b0;
        st_intt = st;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          rdy[i] = in_ready_0;
          drn[i] = draining_0;
          v[i]   = valid_0;
          if (i <= 6 && ctrl_0 === PE_MODE_NTT) ctrl_ntt++;
          if (i == 7) ctrl_after = ctrl_0;
        end
      end
    join
    n_checks++;
    if (!all_got || st_intt != 3) begin
      n_fail++;
      $display("FAIL drain_stall all_accepted=%b intt_stalls=%0d, expected 1 3", all_got, st_intt);
    end
    n_checks++;
    if (rdy[6:0] !== 7'b1000111) begin
      n_fail++;
      $display("FAIL drain_ready got %b, expected 1000111", rdy[6:0]);
    end
    n_checks++;
    if (drn[7:0] !== 8'b01110000) begin
      n_fail++;
      $display("FAIL drain_flag got %b, expected 01110000", drn[7:0]);
    end
    n_checks++;
    if (ctrl_ntt != 7 || ctrl_after !== PE_MODE_INTT) begin
      n_fail++;
      $display("FAIL drain_ctrl ntt_cycles=%0d ctrl_after=%0d, expected 7 1", ctrl_ntt, ctrl_after);
    end
    n_checks++;
    if (v[7:0] !== 8'b10001110) begin
      n_fail++;
      $display("FAIL drain_valid got %b, expected 10001110", v[7:0]);
    end
    wait_idle("drain");
  endtask

  task automatic test_credit();
    bit [19:0] rdy, pv;
    int        nacc = 0, occ = 0, occ_max = 0, viol = 0, nv = 0, ctrl_bad = 0;
    fork
      begin
        bit got;
        int st;
        for (int i = 0; i < 6; i++) begin
          send(1, coeff_t'(1000 + i), coeff_t'(i), coeff_t'(3328 - i), PE_MODE_ADDSUB, 12, got, st);
          if (got) nacc++;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          rdy[i] = in_ready_1;
          pv[i]  = pe_valid_1;
          if (valid_1) begin
            nv++;
            if (ctrl_1 !== PE_MODE_ADDSUB) ctrl_bad++;
          end
          if (occ > occ_max) occ_max = occ;
          if (occ == 2 && !pe_valid_1 && in_ready_1) viol++;
          occ = occ + ((in_valid[1] && in_ready_1) ? 1 : 0) - (pe_valid_1 ? 1 : 0);
        end
      end
    join
    n_checks++;
    if (nacc != 6 || nv != 6) begin
      n_fail++;
      $display("FAIL credit_count accepted=%0d issued=%0d, expected 6 6", nacc, nv);
    end
    n_checks++;
    if (occ_max != 2 || viol != 0) begin
      n_fail++;
      $display("FAIL credit_limit max_outstanding=%0d ready_at_full=%0d, expected 2 0", occ_max, viol);
    end
    n_checks++;
    if (rdy[5:0] !== 6'b100011 || pv[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_ready got %b pe_valid@5=%b, expected 100011 1", rdy[5:0], pv[5]);
    end
    n_checks++;
    if (ctrl_bad != 0) begin
      n_fail++;
      $display("FAIL credit_ctrl non-ADDSUB issues=%0d, expected 0", ctrl_bad);
    end
    wait_idle("credit");
  endtask

  task automatic test_underflow();
    bit got;
    int st;
    force_ret = 1'b1;
    @(negedge clk);
    n_checks++;
    if (underflow_0 !== 1'b0 || busy_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_pre uf=%b busy=%b, expected 0 0", underflow_0, busy_0);
    end
    @(posedge clk); #1;
    force_ret = 1'b0;
    @(negedge clk);
    n_checks++;
    if (underflow_0 !== 1'b1 || busy_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_set uf=%b busy=%b, expected 1 0", underflow_0, busy_0);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (underflow_0 !== 1'b1 || underflow_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_sticky uf0=%b uf1=%b, expected 1 0", underflow_0, underflow_1);
    end
    @(posedge clk); #1;
    send(0, 12'd7, 12'd8, 12'd9, PE_MODE_NTT, 4, got, st);
    n_checks++;
    if (!got || st != 0) begin
      n_fail++;
      $display("FAIL underflow_after accepted=%b stalls=%0d, expected 1 0", got, st);
    end
    wait_idle("underflow");
  endtask

  task automatic test_abort();
    bit got;
    int st;
    for (int i = 0; i < 2; i++) begin
      send(0, coeff_t'(400 + i), 12'd1, 12'd1, PE_MODE_NTT, 4, got, st);
    end
    send(0, 12'd999, 12'd999, 12'd999, PE_MODE_MUL, 2, got, st);
    n_checks++;
    if (got) begin
      n_fail++;
      $display("FAIL abort_accept got accepted=1, expected 0");
    end
    @(negedge clk);
    n_checks++;
    if (draining_0 !== 1'b1 || valid_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold draining=%b valid=%b, expected 1 0", draining_0, valid_0);
    end
    @(negedge clk);
    n_checks++;
    if (draining_0 !== 1'b0 || valid_0 !== 1'b0 || ctrl_0 !== PE_MODE_NTT) begin
      n_fail++;
      $display("FAIL abort_exit draining=%b valid=%b ctrl=%0d, expected 0 0 0", draining_0, valid_0, ctrl_0);
    end
    @(posedge clk); #1;
    wait_idle("abort");
  endtask

  task automatic test_random();
    bit       got;
    int       st, nacc = 0, ret0;
    pe_mode_e m = PE_MODE_NTT;
    ret0 = m_returns;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) m = pe_mode_e'(2'($urandom_range(0, 3)));
      send(0, coeff_t'($urandom_range(0, 3328)), coeff_t'($urandom_range(0, 3328)),
           coeff_t'($urandom_range(0, 3328)), m, 50, got, st);
      if (got) nacc++;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    wait_idle("random");
    n_checks++;
    if (nacc != 200) begin
      n_fail++;
      $display("FAIL random_accept got %0d, expected 200", nacc);
    end
    n_checks++;
    if (m_returns - ret0 != 200 || sb.size() != 0 || flight.size() != 0) begin
      n_fail++;
      $display("FAIL random_returns returned=%0d pending_issue=%0d in_flight=%0d, expected 200 0 0",
               m_returns - ret0, sb.size(), flight.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_a[i]     = '0;
      in_b[i]     = '0;
      in_w[i]     = '0;
      in_mode[i]  = PE_MODE_NTT;
    end
    force_ret = 1'b0;
    test_reset();
    test_stream();
    test_mode_drain();
    test_credit();
    test_underflow();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within 500000 ns");
    $fatal(1, "watchdog");
  end

endmodule
